// File: rtl/dm_responder_pkg.sv
// dm_responder_pkg: FSM state encodings and request-type constants shared by the data-memory responder.
package dm_responder_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAIT   = 2'b01,
        ACCESS = 2'b10,
        RESP   = 2'b11
    } state_e;
    localparam logic REQ_LOAD  = 1'b0;
    localparam logic REQ_STORE = 1'b1;
endpackage

// File: rtl/dm_array.sv
// dm_array: single-port synchronous word RAM with registered read data; contents are never reset.
module dm_array #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);
    logic [31:0] mem_q [2**DEPTH_LOG2];
    always_ff @(posedge clk) begin
        if (we) mem_q[idx] <= wdata;
        rdata <= mem_q[idx];
    end
endmodule

// File: rtl/dm_responder.sv
// dm_responder: slow data-memory responder with programmable wait states and a one-cycle response pulse.
// Optional MEM_MISALIGN_CHK_EN: misaligned accesses are suppressed and flagged on rsp_err.
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam logic [3:0] WC = 4'(WAIT_CYCLES);

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  accept, mis, arr_we;
    logic [31:0]           arr_rdata;

    assign accept = state_q == IDLE && req_valid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: if (req_valid) begin
                state_d = WC == 4'd0 ? ACCESS : WAIT;
                cnt_d   = WC;
                we_d    = req_we;
                idx_d   = req_addr[DEPTH_LOG2+1:2];
                wdata_d = req_wdata;
            end
            WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = cnt_q <= 4'd1 ? ACCESS : WAIT;
            end
            ACCESS:  state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= REQ_LOAD;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef MEM_MISALIGN_CHK_EN
    logic mis_q;
    logic unused_addr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mis_q <= 1'b0;
        else        mis_q <= accept ? |req_addr[1:0] : mis_q;
    end
    assign mis         = mis_q;
    assign unused_addr = ^req_addr[31:DEPTH_LOG2+2];
`else
    logic unused_addr;
    assign mis         = 1'b0;
    assign unused_addr = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};
`endif

    // The store commits on the edge that leaves ACCESS; a reset before then drops it.
    assign arr_we    = state_q == ACCESS && we_q == REQ_STORE && !mis;
    assign req_ready = state_q == IDLE;
    assign rsp_valid = state_q == RESP;
    assign rsp_err   = rsp_valid && mis;
    assign rsp_rdata = rsp_valid && we_q == REQ_LOAD && !mis ? arr_rdata : '0;

    dm_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
        .clk   (clk),
        .we    (arr_we),
        .idx   (idx_q),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed checks of latency, handshake, aliasing, reset abort and misalignment.
module tb_dm_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rdy2, rdy0, v2, v0, e2, e0;
    logic [31:0] d2, d0;
    logic        ready_m, valid_m, err_m;
    logic [31:0] rdata_m;
    int          n2 = 0, n0 = 0;
    int          errors = 0, checks = 0;
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          base;

    always #5 clk = ~clk;

    dm_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid && !sel), .req_ready(rdy2),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(v2), .rsp_rdata(d2), .rsp_err(e2)
    );

    dm_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid && sel), .req_ready(rdy0),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(v0), .rsp_rdata(d0), .rsp_err(e0)
    );

    assign ready_m = sel ? rdy0 : rdy2;
    assign valid_m = sel ? v0 : v2;
    assign rdata_m = sel ? d0 : d2;
    assign err_m   = sel ? e0 : e2;

    always @(posedge clk) begin
        if (v2) n2++;
        if (v0) n0++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic s, input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic hold, output logic [31:0] r, output logic e, output int l);
        int c0;
        @(negedge clk);
        sel = s; req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
        chk("ready_idle", {31'b0, ready_m}, 32'd1);
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
        c0 = s ? n0 : n2;
        l = 0; r = '0; e = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (valid_m) begin
                l = i; r = rdata_m; e = err_m;
                break;
            end
            if (hold) chk("ready_busy", {31'b0, ready_m}, 32'd0);
        end
        req_valid = 1'b0;
        @(negedge clk);
        chk("pulse_end", {31'b0, valid_m}, 32'd0);
        chk("rdata_clear", rdata_m, 32'd0);
        chk("err_clear", {31'b0, err_m}, 32'd0);
        chk("one_rsp", (s ? n0 : n2) - c0, 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, rdy2}, 32'd1);
        chk("rst_valid", {31'b0, v2}, 32'd0);
        chk("rst_rdata", d2, 32'd0);
        chk("rst_err", {31'b0, e2}, 32'd0);
        rst_n = 1'b1;

        do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, rd, er, lat);
        chk("sw_lat", lat, 32'd4);
        chk("sw_rdata", rd, 32'd0);
        do_req(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, rd, er, lat);
        chk("lw_lat", lat, 32'd4);
        chk("lw_rdata", rd, 32'hDEADBEEF);

        do_req(1'b0, 1'b0, 32'h10, 32'h0, 1'b1, rd, er, lat);
        chk("hold_lat", lat, 32'd4);
        chk("hold_rdata", rd, 32'hDEADBEEF);

        do_req(1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 1'b0, rd, er, lat);
        chk("w0_sw_lat", lat, 32'd2);
        do_req(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, rd, er, lat);
        chk("w0_lw_lat", lat, 32'd2);
        chk("w0_lw_rdata", rd, 32'hCAFEF00D);

        do_req(1'b0, 1'b1, 32'h0, 32'h1234, 1'b0, rd, er, lat);
        do_req(1'b0, 1'b0, 32'h1000, 32'h0, 1'b0, rd, er, lat);
        chk("alias_1000", rd, 32'h1234);
        do_req(1'b0, 1'b0, 32'hFFFFF010, 32'h0, 1'b0, rd, er, lat);
        chk("alias_high", rd, 32'hDEADBEEF);

        do_req(1'b0, 1'b1, 32'h20, 32'h11112222, 1'b0, rd, er, lat);
        @(negedge clk);
        sel = 1'b0; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hAAAA5555; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        base = n2;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_rsp", {31'b0, v2}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", {31'b0, rdy2}, 32'd1);
        chk("abort_cnt", n2 - base, 32'd0);
        do_req(1'b0, 1'b0, 32'h20, 32'h0, 1'b0, rd, er, lat);
        chk("abort_old", rd, 32'h11112222);

        do_req(1'b0, 1'b1, 32'h22, 32'hFFFFFFFF, 1'b0, rd, er, lat);
        do_req(1'b0, 1'b0, 32'h20, 32'h0, 1'b0, rd, er, lat);
`ifdef MEM_MISALIGN_CHK_EN
        chk("mis_lw_keep", rd, 32'h11112222);
        do_req(1'b0, 1'b0, 32'h22, 32'h0, 1'b0, rd, er, lat);
        chk("mis_err", {31'b0, er}, 32'd1);
        chk("mis_rdata", rd, 32'd0);
`else
        chk("mis_lw_new", rd, 32'hFFFFFFFF);
        do_req(1'b0, 1'b0, 32'h22, 32'h0, 1'b0, rd, er, lat);
        chk("mis_err", {31'b0, er}, 32'd0);
        chk("mis_rdata", rd, 32'hFFFFFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
